// File: rtl/addsub_reservation_station.sv
// Reservation station feeding the add/sub functional unit of a Tomasulo datapath.
// Optional macro OLDEST_FIRST_EN: dispatch the oldest READY entry instead of the lowest index.
module addsub_reservation_station #(
    parameter int DATA_W     = 9,
    parameter int TAG_W      = 3,
    parameter int ENTRIES    = 2,
    parameter int LABEL_BASE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Issue,
    input  logic [2:0]        IssueOpCode,
    input  logic [2:0]        IssueX,
    input  logic [DATA_W-1:0] IssueVj,
    input  logic [DATA_W-1:0] IssueVk,
    input  logic [TAG_W-1:0]  IssueQj,
    input  logic [TAG_W-1:0]  IssueQk,
    output logic              Full,
    output logic [TAG_W-1:0]  IssueLabel,
    input  logic              CdbValid,
    input  logic [TAG_W-1:0]  CdbLabel,
    input  logic [DATA_W-1:0] CdbData,
    output logic              RUN,
    output logic [DATA_W-1:0] RegY,
    output logic [DATA_W-1:0] RegZ,
    output logic [2:0]        OpCode,
    output logic [2:0]        XAddSub,
    output logic [TAG_W-1:0]  LabelAddSub,
    input  logic              Done,
    input  logic [TAG_W-1:0]  Label
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} ent_state_e;

    ent_state_e        state_q [ENTRIES];
    ent_state_e        state_d [ENTRIES];
    logic [DATA_W-1:0] vj_q    [ENTRIES];
    logic [DATA_W-1:0] vj_d    [ENTRIES];
    logic [DATA_W-1:0] vk_q    [ENTRIES];
    logic [DATA_W-1:0] vk_d    [ENTRIES];
    logic [TAG_W-1:0]  qj_q    [ENTRIES];
    logic [TAG_W-1:0]  qj_d    [ENTRIES];
    logic [TAG_W-1:0]  qk_q    [ENTRIES];
    logic [TAG_W-1:0]  qk_d    [ENTRIES];
    logic [2:0]        op_q    [ENTRIES];
    logic [2:0]        op_d    [ENTRIES];
    logic [2:0]        x_q     [ENTRIES];
    logic [2:0]        x_d     [ENTRIES];

    logic              run_q, run_d;
    logic [DATA_W-1:0] regy_q, regy_d;
    logic [DATA_W-1:0] regz_q, regz_d;
    logic [2:0]        opout_q, opout_d;
    logic [2:0]        xout_q, xout_d;
    logic [TAG_W-1:0]  labout_q, labout_d;

    logic              any_free;
    logic [IDX_W-1:0]  free_idx;
    logic              issue_acc;
    logic              any_ready;
    logic [IDX_W-1:0]  disp_idx;
    logic              any_exec;
    logic              dispatch;
    logic              done_hit;
    logic [IDX_W-1:0]  done_idx;
    logic              byp_j, byp_k;
    logic [TAG_W-1:0]  new_qj, new_qk;
    logic [DATA_W-1:0] new_vj, new_vk;

    function automatic logic [TAG_W-1:0] own_label(input int idx);
        return TAG_W'(LABEL_BASE + idx);
    endfunction

    // Lowest-index free entry; Full and IssueLabel come from registered state only.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign Full       = ~any_free;
    assign IssueLabel = any_free ? own_label(int'(free_idx)) : own_label(0);
    assign issue_acc  = Issue & any_free;

    always_comb begin
        any_exec = 1'b0;
        done_hit = 1'b0;
        done_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_EXEC) begin
                any_exec = 1'b1;
                if (Done && (Label == own_label(i))) begin
                    done_hit = 1'b1;
                    done_idx = IDX_W'(i);
                end
            end
        end
    end

`ifdef OLDEST_FIRST_EN
    logic [IDX_W-1:0] rank_q [ENTRIES];
    logic [IDX_W-1:0] rank_d [ENTRIES];
    logic [IDX_W-1:0] best_rank;

    always_comb begin
        any_ready = 1'b0;
        disp_idx  = '0;
        best_rank = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_READY && (!any_ready || rank_q[i] > best_rank)) begin
                any_ready = 1'b1;
                disp_idx  = IDX_W'(i);
                best_rank = rank_q[i];
            end
        end
    end

    // Ranks stay compact (0..valid-1): entries older than a freed one close the gap.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            rank_d[i] = rank_q[i];
            if (done_hit && (done_idx == IDX_W'(i))) begin
                rank_d[i] = '0;
            end else if (state_q[i] != ST_FREE) begin
                if (done_hit && rank_q[i] > rank_q[done_idx]) begin
                    rank_d[i] = rank_d[i] - 1'b1;
                end
                if (issue_acc) begin
                    rank_d[i] = rank_d[i] + 1'b1;
                end
            end
            if (issue_acc && (free_idx == IDX_W'(i))) begin
                rank_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) rank_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) rank_q[i] <= rank_d[i];
        end
    end
`else
    always_comb begin
        any_ready = 1'b0;
        disp_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_READY) begin
                any_ready = 1'b1;
                disp_idx  = IDX_W'(i);
            end
        end
    end
`endif

    assign dispatch = ~run_q & ~any_exec & any_ready;

    // Issue-cycle bypass: a tag being broadcast right now is resolved on entry.
    always_comb begin
        byp_j  = CdbValid && (IssueQj != '0) && (IssueQj == CdbLabel);
        byp_k  = CdbValid && (IssueQk != '0) && (IssueQk == CdbLabel);
        new_qj = byp_j ? '0 : IssueQj;
        new_qk = byp_k ? '0 : IssueQk;
        new_vj = byp_j ? CdbData : IssueVj;
        new_vk = byp_k ? CdbData : IssueVk;
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            op_d[i]    = op_q[i];
            x_d[i]     = x_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (issue_acc && (free_idx == IDX_W'(i))) begin
                        vj_d[i]    = new_vj;
                        vk_d[i]    = new_vk;
                        qj_d[i]    = new_qj;
                        qk_d[i]    = new_qk;
                        op_d[i]    = IssueOpCode;
                        x_d[i]     = IssueX;
                        state_d[i] = ((new_qj == '0) && (new_qk == '0)) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (CdbValid && (qj_q[i] != '0) && (qj_q[i] == CdbLabel)) begin
                        vj_d[i] = CdbData;
                        qj_d[i] = '0;
                    end
                    if (CdbValid && (qk_q[i] != '0) && (qk_q[i] == CdbLabel)) begin
                        vk_d[i] = CdbData;
                        qk_d[i] = '0;
                    end
                    if ((qj_d[i] == '0) && (qk_d[i] == '0)) begin
                        state_d[i] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (dispatch && (disp_idx == IDX_W'(i))) begin
                        state_d[i] = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (done_hit && (done_idx == IDX_W'(i))) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: state_d[i] = ST_FREE;
            endcase
        end
    end

    // Unit-side registers change only on dispatch or on the matching Done.
    always_comb begin
        run_d    = run_q;
        regy_d   = regy_q;
        regz_d   = regz_q;
        opout_d  = opout_q;
        xout_d   = xout_q;
        labout_d = labout_q;
        if (done_hit) begin
            run_d = 1'b0;
        end else if (dispatch) begin
            run_d    = 1'b1;
            regy_d   = vj_q[disp_idx];
            regz_d   = vk_q[disp_idx];
            opout_d  = op_q[disp_idx];
            xout_d   = x_q[disp_idx];
            labout_d = own_label(int'(disp_idx));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                op_q[i]    <= '0;
                x_q[i]     <= '0;
            end
            run_q    <= 1'b0;
            regy_q   <= '0;
            regz_q   <= '0;
            opout_q  <= '0;
            xout_q   <= '0;
            labout_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                qj_q[i]    <= qj_d[i];
                qk_q[i]    <= qk_d[i];
                op_q[i]    <= op_d[i];
                x_q[i]     <= x_d[i];
            end
            run_q    <= run_d;
            regy_q   <= regy_d;
            regz_q   <= regz_d;
            opout_q  <= opout_d;
            xout_q   <= xout_d;
            labout_q <= labout_d;
        end
    end

    assign RUN         = run_q;
    assign RegY        = regy_q;
    assign RegZ        = regz_q;
    assign OpCode      = opout_q;
    assign XAddSub     = xout_q;
    assign LabelAddSub = labout_q;

endmodule

// File: tb/tb_addsub_reservation_station.sv
// Scoreboard bench for addsub_reservation_station: expected dispatches are queued at issue
// time and checked by a monitor whenever RUN rises; directed checks cover latency and control.
module tb_addsub_reservation_station;

    logic       clk = 1'b0;
    logic       reset;
    logic       Issue;
    logic [2:0] IssueOpCode, IssueX;
    logic [8:0] IssueVj, IssueVk;
    logic [2:0] IssueQj, IssueQk;
    logic       Full;
    logic [2:0] IssueLabel;
    logic       CdbValid;
    logic [2:0] CdbLabel;
    logic [8:0] CdbData;
    logic       RUN;
    logic [8:0] RegY, RegZ;
    logic [2:0] OpCode, XAddSub, LabelAddSub;
    logic       Done;
    logic [2:0] Label;

    addsub_reservation_station #(
        .DATA_W(9), .TAG_W(3), .ENTRIES(2), .LABEL_BASE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .Issue(Issue), .IssueOpCode(IssueOpCode), .IssueX(IssueX),
        .IssueVj(IssueVj), .IssueVk(IssueVk), .IssueQj(IssueQj), .IssueQk(IssueQk),
        .Full(Full), .IssueLabel(IssueLabel),
        .CdbValid(CdbValid), .CdbLabel(CdbLabel), .CdbData(CdbData),
        .RUN(RUN), .RegY(RegY), .RegZ(RegZ), .OpCode(OpCode),
        .XAddSub(XAddSub), .LabelAddSub(LabelAddSub),
        .Done(Done), .Label(Label)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] y;
        logic [8:0] z;
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] lbl;
    } disp_t;

    disp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  run_prev = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic expect_disp(input logic [8:0] y, input logic [8:0] z, input logic [2:0] op,
                               input logic [2:0] x, input logic [2:0] lbl);
        disp_t e;
        e.y = y; e.z = z; e.op = op; e.x = x; e.lbl = lbl;
        exp_q.push_back(e);
    endtask

    // Monitor: each rising RUN is one dispatch and must match the oldest expectation.
    always @(negedge clk) begin : monitor
        disp_t e;
        if (RUN && !run_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_dispatch: label %0d, none expected", LabelAddSub);
            end else begin
                e = exp_q.pop_front();
                chk("disp_RegY", int'(RegY), int'(e.y));
                chk("disp_RegZ", int'(RegZ), int'(e.z));
                chk("disp_OpCode", int'(OpCode), int'(e.op));
                chk("disp_XAddSub", int'(XAddSub), int'(e.x));
                chk("disp_Label", int'(LabelAddSub), int'(e.lbl));
            end
        end
        run_prev <= RUN;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue_op(input logic [2:0] op, input logic [2:0] x, input logic [8:0] vj,
                            input logic [8:0] vk, input logic [2:0] qj, input logic [2:0] qk);
        Issue = 1'b1; IssueOpCode = op; IssueX = x;
        IssueVj = vj; IssueVk = vk; IssueQj = qj; IssueQk = qk;
        @(negedge clk);
        Issue = 1'b0; IssueQj = 3'd0; IssueQk = 3'd0;
    endtask

    task automatic cdb(input logic [2:0] l, input logic [8:0] d);
        CdbValid = 1'b1; CdbLabel = l; CdbData = d;
        @(negedge clk);
        CdbValid = 1'b0; CdbLabel = 3'd0; CdbData = 9'd0;
    endtask

    task automatic done_lbl(input logic [2:0] l);
        Done = 1'b1; Label = l;
        @(negedge clk);
        Done = 1'b0; Label = 3'd0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0] first_lbl, second_lbl;
        reset = 1'b1; Issue = 1'b0; IssueOpCode = 3'd0; IssueX = 3'd0;
        IssueVj = 9'd0; IssueVk = 9'd0; IssueQj = 3'd0; IssueQk = 3'd0;
        CdbValid = 1'b0; CdbLabel = 3'd0; CdbData = 9'd0; Done = 1'b0; Label = 3'd0;
        tick(2);
        chk("reset_RUN", int'(RUN), 0);
        chk("reset_Full", int'(Full), 0);
        chk("reset_IssueLabel", int'(IssueLabel), 1);
        chk("reset_RegY", int'(RegY), 0);
        chk("reset_LabelAddSub", int'(LabelAddSub), 0);
        reset = 1'b0;
        tick(1);

        // Ready-at-issue ADD; stray Done is ignored.
        expect_disp(9'd5, 9'd7, 3'd0, 3'd3, 3'd1);
        issue_op(3'd0, 3'd3, 9'd5, 9'd7, 3'd0, 3'd0);
        chk("t1_no_same_cycle_run", int'(RUN), 0);
        chk("t1_issuelabel_next", int'(IssueLabel), 2);
        tick(1);
        chk("t1_run_up", int'(RUN), 1);
        done_lbl(3'd2);
        chk("t1_stray_done_ignored", int'(RUN), 1);
        done_lbl(3'd1);
        chk("t1_run_down", int'(RUN), 0);
        chk("t1_full", int'(Full), 0);
        chk("t1_issuelabel", int'(IssueLabel), 1);

        // SUB waiting on tag 4; wrong tag first, then the producer.
        expect_disp(9'd10, 9'd2, 3'd1, 3'd4, 3'd1);
        issue_op(3'd1, 3'd4, 9'h55, 9'd2, 3'd4, 3'd0);
        chk("t2_wait_no_run", int'(RUN), 0);
        cdb(3'd7, 9'd99);
        tick(1);
        chk("t2_wrong_tag_no_run", int'(RUN), 0);
        cdb(3'd4, 9'd10);
        tick(1);
        chk("t2_run_after_capture", int'(RUN), 1);
        done_lbl(3'd1);
        chk("t2_run_down", int'(RUN), 0);

        // Issue-cycle bypass on both operands.
        expect_disp(9'd9, 9'd9, 3'd0, 3'd5, 3'd1);
        CdbValid = 1'b1; CdbLabel = 3'd5; CdbData = 9'd9;
        issue_op(3'd0, 3'd5, 9'd1, 9'd1, 3'd5, 3'd5);
        CdbValid = 1'b0; CdbLabel = 3'd0; CdbData = 9'd0;
        chk("t3_no_same_cycle_run", int'(RUN), 0);
        tick(1);
        chk("t3_run_up", int'(RUN), 1);
        done_lbl(3'd1);

        // Fill both entries; third issue must be dropped.
        expect_disp(9'd1, 9'd2, 3'd0, 3'd1, 3'd1);
        expect_disp(9'd3, 9'd4, 3'd0, 3'd2, 3'd2);
        issue_op(3'd0, 3'd1, 9'd1, 9'd2, 3'd0, 3'd0);
        issue_op(3'd0, 3'd2, 9'd3, 9'd4, 3'd0, 3'd0);
        chk("t4_full", int'(Full), 1);
        issue_op(3'd1, 3'd7, 9'd100, 9'd100, 3'd0, 3'd0);
        chk("t4_still_full", int'(Full), 1);
        chk("t4_exec_label", int'(LabelAddSub), 1);
        done_lbl(3'd1);
        chk("t4_full_cleared", int'(Full), 0);
        chk("t4_issuelabel", int'(IssueLabel), 1);
        chk("t4_run_gap", int'(RUN), 0);
        tick(1);
        chk("t4_second_run", int'(RUN), 1);
        chk("t4_second_label", int'(LabelAddSub), 2);
        done_lbl(3'd2);
        chk("t4_empty", int'(Full), 0);

        // Entry1 (older) and entry0 (younger) become READY together while the unit is idle.
        expect_disp(9'd11, 9'd12, 3'd0, 3'd1, 3'd1);
        issue_op(3'd0, 3'd1, 9'd11, 9'd12, 3'd0, 3'd0);
        issue_op(3'd1, 3'd2, 9'd0, 9'd0, 3'd6, 3'd6);
        chk("t5_a_running", int'(RUN), 1);
        done_lbl(3'd1);
        chk("t5_issuelabel", int'(IssueLabel), 1);
        issue_op(3'd0, 3'd3, 9'd0, 9'd13, 3'd6, 3'd0);
        chk("t5_both_wait", int'(RUN), 0);
`ifdef OLDEST_FIRST_EN
        first_lbl = 3'd2; second_lbl = 3'd1;
        expect_disp(9'd50, 9'd50, 3'd1, 3'd2, 3'd2);
        expect_disp(9'd50, 9'd13, 3'd0, 3'd3, 3'd1);
`else
        first_lbl = 3'd1; second_lbl = 3'd2;
        expect_disp(9'd50, 9'd13, 3'd0, 3'd3, 3'd1);
        expect_disp(9'd50, 9'd50, 3'd1, 3'd2, 3'd2);
`endif
        cdb(3'd6, 9'd50);
        tick(1);
        chk("t5_first_pick", int'(LabelAddSub), int'(first_lbl));
        done_lbl(first_lbl);
        chk("t5_run_gap", int'(RUN), 0);
        tick(1);
        chk("t5_second_pick", int'(LabelAddSub), int'(second_lbl));
        done_lbl(second_lbl);

        // Asynchronous reset while executing.
        expect_disp(9'd1, 9'd1, 3'd0, 3'd6, 3'd1);
        issue_op(3'd0, 3'd6, 9'd1, 9'd1, 3'd0, 3'd0);
        tick(1);
        chk("t6_run_before_reset", int'(RUN), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_run", int'(RUN), 0);
        chk("t6_async_regy", int'(RegY), 0);
        chk("t6_async_label", int'(LabelAddSub), 0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_full", int'(Full), 0);
        chk("t6_issuelabel", int'(IssueLabel), 1);
        done_lbl(3'd1);
        chk("t6_stale_done", int'(RUN), 0);
        tick(2);
        chk("t6_still_idle", int'(RUN), 0);
        chk("t6_still_empty", int'(Full), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
